// File: rtl/perceptron_trainer.sv
// Single-neuron perceptron trainer: streams labelled 2-input samples, updates
// saturating 4-bit weights/bias on each misclassification, stops on a clean epoch or the epoch limit.
module perceptron_trainer #(
    parameter int MAX_EPOCH = 15,
    parameter int STEP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic signed [3:0] init_wA,
    input  logic signed [3:0] init_wB,
    input  logic signed [3:0] init_b,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [1:0]        sample_x,
    input  logic              sample_t,
    input  logic              sample_last,
    output logic signed [3:0] wA,
    output logic signed [3:0] wB,
    output logic signed [3:0] b,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [3:0]        epoch,
    output logic [2:0]        err_cnt,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EVAL   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic signed [4:0] STEP_D = 5'(STEP);

    state_t            state;
    state_t            state_n;
    logic [1:0]        x_q;
    logic              t_q;
    logic              last_q;
    logic              err_pos;
    logic              err_neg;
    logic signed [3:0] holder;
    logic              pred;
    logic signed [4:0] delta;
    logic              epoch_clean;
    logic              last_epoch;

    function automatic logic signed [3:0] sat_add(input logic signed [3:0] w,
                                                  input logic signed [4:0] d);
        logic signed [5:0] s;
        s = {{2{w[3]}}, w} + {d[4], d};
        if (s > 6'sd7)
            return 4'sd7;
        else if (s < -6'sd8)
            return -4'sd8;
        else
            return s[3:0];
    endfunction

    // Weighted sum in plain 4-bit arithmetic, so overflow wraps rather than saturates.
    always_comb begin
        holder = -b;
        if (x_q[0])
            holder = holder + wA;
        if (x_q[1])
            holder = holder + wB;
    end

    assign pred        = (holder > 4'sd0);
    assign delta       = err_pos ? STEP_D : -STEP_D;
    assign epoch_clean = (err_cnt == 3'd0) && !(err_pos || err_neg);
    assign last_epoch  = (epoch == 4'(MAX_EPOCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // A sample transfers on a cycle where sample_valid and sample_ready are both
    // high; ready is raised only in FETCH, and valid is ignored in every other state.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_n = S_FETCH;
            S_FETCH:        if (sample_valid) state_n = S_EVAL;
            S_EVAL:         state_n = S_UPDATE;
            S_UPDATE:       state_n = (last_q && (epoch_clean || last_epoch)) ? S_DONE : S_FETCH;
            default:        state_n = S_IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (state == S_FETCH);
        busy         = (state == S_FETCH) || (state == S_EVAL) || (state == S_UPDATE);
        fsm_state    = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wA        <= '0;
            wB        <= '0;
            b         <= '0;
            epoch     <= '0;
            err_cnt   <= '0;
            converged <= 1'b0;
            done      <= 1'b0;
            x_q       <= '0;
            t_q       <= 1'b0;
            last_q    <= 1'b0;
            err_pos   <= 1'b0;
            err_neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        wA        <= init_wA;
                        wB        <= init_wB;
                        b         <= init_b;
                        epoch     <= 4'd1;
                        err_cnt   <= '0;
                        converged <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (sample_valid) begin
                        x_q    <= sample_x;
                        t_q    <= sample_t;
                        last_q <= sample_last;
                    end
                end
                S_EVAL: begin
                    err_pos <= t_q & ~pred;
                    err_neg <= ~t_q & pred;
                end
                S_UPDATE: begin
                    if (err_pos || err_neg) begin
                        if (x_q[0])
                            wA <= sat_add(wA, delta);
                        if (x_q[1])
                            wB <= sat_add(wB, delta);
                        b <= sat_add(b, -delta);
                        if (err_cnt != 3'd7)
                            err_cnt <= err_cnt + 3'd1;
                    end
                    // End of epoch: a later err_cnt clear overrides the increment above.
                    if (last_q) begin
                        if (epoch_clean) begin
                            converged <= 1'b1;
                            done      <= 1'b1;
                        end else if (last_epoch) begin
                            converged <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            epoch   <= epoch + 4'd1;
                            err_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: two instances (default and short/large-step) driven
// by directed and random training runs, checked every cycle against a transaction model.
module tb_perceptron_trainer;

    localparam int M1 = 3;
    localparam int S1 = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              start [2];
    logic signed [3:0] init_wa [2];
    logic signed [3:0] init_wb [2];
    logic signed [3:0] init_b [2];
    logic              sample_valid [2];
    logic              sample_ready [2];
    logic [1:0]        sample_x [2];
    logic              sample_t [2];
    logic              sample_last [2];
    logic signed [3:0] wa [2];
    logic signed [3:0] wb [2];
    logic signed [3:0] bo [2];
    logic              busy [2];
    logic              done [2];
    logic              converged [2];
    logic [3:0]        epoch [2];
    logic [2:0]        err_cnt [2];
    logic [2:0]        fsm_state [2];

    perceptron_trainer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .init_wA(init_wa[0]), .init_wB(init_wb[0]), .init_b(init_b[0]),
        .sample_valid(sample_valid[0]), .sample_ready(sample_ready[0]),
        .sample_x(sample_x[0]), .sample_t(sample_t[0]), .sample_last(sample_last[0]),
        .wA(wa[0]), .wB(wb[0]), .b(bo[0]), .busy(busy[0]), .done(done[0]),
        .converged(converged[0]), .epoch(epoch[0]), .err_cnt(err_cnt[0]),
        .fsm_state(fsm_state[0])
    );

    perceptron_trainer #(.MAX_EPOCH(M1), .STEP(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .init_wA(init_wa[1]), .init_wB(init_wb[1]), .init_b(init_b[1]),
        .sample_valid(sample_valid[1]), .sample_ready(sample_ready[1]),
        .sample_x(sample_x[1]), .sample_t(sample_t[1]), .sample_last(sample_last[1]),
        .wA(wa[1]), .wB(wb[1]), .b(bo[1]), .busy(busy[1]), .done(done[1]),
        .converged(converged[1]), .epoch(epoch[1]), .err_cnt(err_cnt[1]),
        .fsm_state(fsm_state[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Expected outputs of each instance.
    int m_wa [2];
    int m_wb [2];
    int m_b [2];
    int m_epoch [2];
    int m_err [2];
    int m_conv [2];
    int m_busy [2];
    int m_ready [2];
    int m_done [2];

    logic [1:0] set_x [8];
    logic       set_t [8];
    int         set_n;

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : S1;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 15 : M1;
    endfunction

    function automatic int clamp(input int v);
        return (v > 7) ? 7 : ((v < -8) ? -8 : v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wa[i] = 0; m_wb[i] = 0; m_b[i] = 0; m_epoch[i] = 0; m_err[i] = 0;
            m_conv[i] = 0; m_busy[i] = 0; m_ready[i] = 0; m_done[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d wA", i), int'(wa[i]), m_wa[i]);
                chk($sformatf("dut%0d wB", i), int'(wb[i]), m_wb[i]);
                chk($sformatf("dut%0d b", i), int'(bo[i]), m_b[i]);
                chk($sformatf("dut%0d epoch", i), int'(epoch[i]), m_epoch[i]);
                chk($sformatf("dut%0d err_cnt", i), int'(err_cnt[i]), m_err[i]);
                chk($sformatf("dut%0d converged", i), int'(converged[i]), m_conv[i]);
                chk($sformatf("dut%0d busy", i), int'(busy[i]), m_busy[i]);
                chk($sformatf("dut%0d sample_ready", i), int'(sample_ready[i]), m_ready[i]);
                chk($sformatf("dut%0d done", i), int'(done[i]), m_done[i]);
            end
        end
    end

    // Called at posedge+1 with the instance in IDLE or DONE.
    task automatic do_start(input int i, input int a, input int bb, input int c);
        start[i] = 1'b1;
        init_wa[i] = 4'(a);
        init_wb[i] = 4'(bb);
        init_b[i] = 4'(c);
        @(posedge clk);
        m_wa[i] = a; m_wb[i] = bb; m_b[i] = c;
        m_epoch[i] = 1; m_err[i] = 0; m_conv[i] = 0;
        m_busy[i] = 1; m_ready[i] = 1; m_done[i] = 0;
        #1 start[i] = 1'b0;
    endtask

    // Called at posedge+1 with the instance in FETCH; fin reports training end.
    task automatic send_sample(input int i, input logic [1:0] x, input logic t,
                               input logic last, input bit noisy, input int stall,
                               output bit fin);
        int k, h, pred, e, st, x1, x2, nwa, nwb, nb, nerr;
        fin = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (noisy) begin
                start[i] = 1'b1;
                init_wa[i] = 4'($urandom_range(0, 15));
                init_wb[i] = 4'($urandom_range(0, 15));
                init_b[i] = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
        end
        start[i] = 1'b0;
        sample_valid[i] = 1'b1;
        sample_x[i] = x;
        sample_t[i] = t;
        sample_last[i] = last;
        k = 0;
        while (!sample_ready[i] && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!sample_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d handshake timeout sample_ready got 0 expected 1", i);
            sample_valid[i] = 1'b0;
            fin = 1'b1;
            return;
        end
        @(posedge clk);
        m_ready[i] = 0;
        st = step_of(i);
        x1 = x[0] ? 1 : 0;
        x2 = x[1] ? 1 : 0;
        h = x1 * m_wa[i] + x2 * m_wb[i] - m_b[i];
        h = ((h % 16) + 16) % 16;
        if (h > 7) h -= 16;
        pred = (h > 0) ? 1 : 0;
        e = (t ? 1 : 0) - pred;
        nwa = clamp(m_wa[i] + st * e * x1);
        nwb = clamp(m_wb[i] + st * e * x2);
        nb = clamp(m_b[i] - st * e);
        nerr = (e != 0) ? ((m_err[i] >= 7) ? 7 : m_err[i] + 1) : m_err[i];
        #1;
        if (noisy) begin
            sample_x[i] = ~x;
            sample_t[i] = ~t;
            sample_last[i] = ~last;
        end else begin
            sample_valid[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (noisy) begin
            start[i] = 1'b1;
            init_wa[i] = 4'($urandom_range(0, 15));
            init_wb[i] = 4'($urandom_range(0, 15));
            init_b[i] = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        m_wa[i] = nwa; m_wb[i] = nwb; m_b[i] = nb; m_err[i] = nerr;
        if (last) begin
            if (nerr == 0) begin
                m_conv[i] = 1;
                fin = 1'b1;
            end else if (m_epoch[i] == max_of(i)) begin
                m_conv[i] = 0;
                fin = 1'b1;
            end else begin
                m_epoch[i] = m_epoch[i] + 1;
                m_err[i] = 0;
            end
        end
        if (fin) begin
            m_busy[i] = 0; m_ready[i] = 0; m_done[i] = 1;
        end else begin
            m_ready[i] = 1;
        end
        #1;
        start[i] = 1'b0;
        sample_valid[i] = 1'b0;
        if (fin) begin
            @(posedge clk);
            m_done[i] = 0;
            #1;
        end
    endtask

    task automatic train(input int i, input bit noisy);
        bit fin;
        int guard;
        fin = 1'b0;
        guard = 0;
        while (!fin && guard < 40) begin
            for (int k = 0; k < set_n && !fin; k++)
                send_sample(i, set_x[k], set_t[k], (k == set_n - 1), noisy,
                            noisy ? int'($urandom_range(0, 10)) : 0, fin);
            guard++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL dut%0d training never ended epoch got %0d", i, int'(epoch[i]));
        end
    endtask

    task automatic load_and();
        set_n = 4;
        set_x[0] = 2'b00; set_t[0] = 1'b0;
        set_x[1] = 2'b10; set_t[1] = 1'b0;
        set_x[2] = 2'b01; set_t[2] = 1'b0;
        set_x[3] = 2'b11; set_t[3] = 1'b1;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit fin;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; init_wa[i] = '0; init_wb[i] = '0; init_b[i] = '0;
            sample_valid[i] = 1'b0; sample_x[i] = '0; sample_t[i] = 1'b0; sample_last[i] = 1'b0;
        end
        model_reset();
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;

        // AND set, default parameters.
        load_and();
        do_start(0, 0, 0, 0);
        train(0, 1'b0);
        chk("and wA", int'(wa[0]), 2);
        chk("and wB", int'(wb[0]), 1);
        chk("and b", int'(bo[0]), 2);
        chk("and epoch", int'(epoch[0]), 6);
        chk("and converged", int'(converged[0]), 1);

        // XOR set on the three-epoch instance.
        set_n = 4;
        set_x[0] = 2'b00; set_t[0] = 1'b0;
        set_x[1] = 2'b01; set_t[1] = 1'b1;
        set_x[2] = 2'b10; set_t[2] = 1'b1;
        set_x[3] = 2'b11; set_t[3] = 1'b0;
        do_start(1, 0, 0, 0);
        train(1, 1'b0);
        chk("xor converged", int'(converged[1]), 0);
        chk("xor epoch", int'(epoch[1]), 3);
        chk("xor busy", int'(busy[1]), 0);

        // Sum wraps to -2, so no update and an immediately clean epoch.
        set_n = 1;
        set_x[0] = 2'b11; set_t[0] = 1'b0;
        do_start(0, 7, 7, 0);
        train(0, 1'b0);
        chk("wrap wA", int'(wa[0]), 7);
        chk("wrap wB", int'(wb[0]), 7);
        chk("wrap b", int'(bo[0]), 0);
        chk("wrap converged", int'(converged[0]), 1);
        chk("wrap epoch", int'(epoch[0]), 1);

        // Saturation, with a 10-cycle stall and start/valid noise around it.
        do_start(0, 7, 0, 7);
        send_sample(0, 2'b01, 1'b1, 1'b0, 1'b1, 10, fin);
        chk("sat wA", int'(wa[0]), 7);
        chk("sat wB", int'(wb[0]), 0);
        chk("sat b", int'(bo[0]), 6);
        chk("sat err_cnt", int'(err_cnt[0]), 1);

        // Reset asserted in the middle of an UPDATE cycle.
        sample_valid[0] = 1'b1;
        sample_x[0] = 2'b10;
        sample_t[0] = 1'b1;
        sample_last[0] = 1'b0;
        @(posedge clk);
        m_ready[0] = 0;
        #1 sample_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d wA", i), int'(wa[i]), 0);
            chk($sformatf("rst%0d wB", i), int'(wb[i]), 0);
            chk($sformatf("rst%0d b", i), int'(bo[i]), 0);
            chk($sformatf("rst%0d busy", i), int'(busy[i]), 0);
            chk($sformatf("rst%0d ready", i), int'(sample_ready[i]), 0);
            chk($sformatf("rst%0d epoch", i), int'(epoch[i]), 0);
            chk($sformatf("rst%0d converged", i), int'(converged[i]), 0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        do_start(0, 1, 1, 1);
        chk("restart wA", int'(wa[0]), 1);
        chk("restart wB", int'(wb[0]), 1);
        chk("restart b", int'(bo[0]), 1);
        chk("restart epoch", int'(epoch[0]), 1);
        load_and();
        train(0, 1'b0);

        // Random training runs on both instances, half of them with stalls and noise.
        for (int r = 0; r < 10; r++) begin
            int i;
            i = r % 2;
            set_n = int'($urandom_range(1, 6));
            for (int k = 0; k < set_n; k++) begin
                set_x[k] = 2'($urandom_range(0, 3));
                set_t[k] = 1'($urandom_range(0, 1));
            end
            do_start(i, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                     int'($urandom_range(0, 15)) - 8);
            train(i, (r >= 4));
        end

        repeat (2) @(posedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter MAX_EPOCH, default 15: epoch limit after which training stops unconverged (range 1-15).
REQ-002 SHALL have parameter STEP, default 1: weight increment magnitude per error (range 1-7).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin training; honoured only in IDLE or DONE.
REQ-006 init_wA, init_wB, init_b  in  4 each, signed  initial weights/bias, sampled on accepted start.
REQ-007 sample_valid  in  1  training sample present.
REQ-008 sample_ready  out  1  trainer accepts sample this cycle.
REQ-009 sample_x  in  2  inputs; x1 = bit0, x2 = bit1.
REQ-010 sample_t  in  1  target label.
REQ-011 sample_last  in  1  sample is last of current epoch.
REQ-012 wA, wB, b  out  4 each, signed  current weights, registered; drive an inner node's wA/wB/b directly.
REQ-013 busy  out  1  high from accepted start until DONE entered.
REQ-014 done  out  1  one-cycle pulse on entry to DONE.
REQ-015 converged  out  1  level; valid in DONE, cleared on next start.
REQ-016 epoch  out  4  epochs processed, including current.
REQ-017 err_cnt  out  3  misclassifications in current epoch, saturating at 7.

Function
REQ-018 FSM states: IDLE, FETCH, EVAL, UPDATE, DONE.
REQ-019 IDLE/DONE + start: load weights from init_*, epoch=1, err_cnt=0, converged=0, busy=1 -> FETCH.
REQ-020 sample_ready=1 only in FETCH; handshake = sample_valid & sample_ready; on handshake latch x, t, last -> EVAL; else stay in FETCH, no state change.
REQ-021 EVAL: holder = x1*wA + x2*wB - b, truncated to 4-bit signed (two's-complement wrap); pred = (holder > 0); err = t - pred in {-1,0,+1} -> UPDATE.
REQ-022 UPDATE: if err != 0: wA += STEP*err*x1, wB += STEP*err*x2, b -= STEP*err, each saturating to [-8,+7]; err_cnt += 1 saturating.
REQ-023 UPDATE, last=0 -> FETCH.
REQ-024 UPDATE, last=1: error-free epoch (err_cnt after this sample = 0) -> converged=1, DONE; else epoch == MAX_EPOCH -> converged=0, DONE; else epoch += 1, err_cnt=0 -> FETCH.
REQ-025 Minimum 3 cycles per sample (FETCH, EVAL, UPDATE).
REQ-026 DONE: busy=0, weights held; done pulses first cycle only; start -> restart per REQ-019.
REQ-027 start ignored in FETCH/EVAL/UPDATE; sample_valid ignored outside FETCH.
REQ-028 Weights change only in UPDATE or on accepted start.

Reset
REQ-029 rst_n low, at any time including mid-epoch: immediately state=IDLE; wA=wB=b=0, sample_ready=0, busy=0, done=0, converged=0, epoch=0, err_cnt=0.
REQ-030 After rst_n deassertion: IDLE, no activity until start.

Verification
REQ-031 AND set: init 0/0/0, epoch = (00,t0),(01,t0),(10,t0),(11,t1,last), repeated -> done, converged=1, epoch=6, wA=2, wB=1, b=2.
REQ-032 XOR set, MAX_EPOCH=3, init 0/0/0 -> done after epoch 3, converged=0, epoch=3, busy=0.
REQ-033 Saturation: init wA=7, wB=0, b=7; sample (x=01b, t=1, last) -> holder=0, err=+1; wA=7 (saturated), wB=0, b=6, err_cnt=1.
REQ-034 Wrap: init wA=7, wB=7, b=0; sample (x=11b, t=0, last) -> holder=-2, pred=0, no error; weights unchanged; converged=1, epoch=1.
REQ-035 Stall/ignore: sample_valid low 10 cycles in FETCH -> sample_ready stays 1, outputs unchanged; valid during EVAL not consumed; start during UPDATE ignored.
REQ-036 Reset mid-UPDATE: rst_n low -> all outputs 0 same cycle; after release, start with init 1/1/1 -> wA=1, wB=1, b=1, epoch=1.
